mem_stage: RTL
==============

Name: mem_stage

Overview:
- LC-3b pipeline memory stage.
- Consumes the EX/MEM pipe contents and performs the data-memory access over a request/response port, including two-access indirect (LDI/STI) and TRAP vector reads.
- Resolves control flow (BR/JMP/JSR/TRAP): drives the fetch-stage PC select and target, and produces mem_stall for the fetch/decode stall logic.
- Owns the MEM/WB pipe register feeding writeback: regfile data, DRID, load_regfile, load_cc, cc data.

Parameters:
- none. All widths are fixed by the lc3b types: word 16, reg id 3, nzp 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_opcode  in  4  lc3b_opcode of the instruction
- ex_ir  in  16  instruction word; [11:9] nzp for BR, [7:0] trapvect8
- ex_alu_out  in  16  ALU result, effective address or branch/jump target
- ex_sr_data  in  16  store data (SR)
- ex_pc  in  16  PC+2 of the instruction
- ex_drid  in  3  destination register id (7 already substituted for JSR/TRAP)
- ex_cc  in  3  current architectural nzp
- dmem_address  out  16  data-memory address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_byte_enable  out  2  lane enables; [1] high byte, [0] low byte
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid with dmem_resp
- dmem_resp  in  1  access complete
- mem_stall  out  1  stage busy; upstream must hold
- pcmux_sel  out  2  0 = PC+2, 1 = target, 2 = trap vector
- pc_target  out  16  redirect address
- wb_valid  out  1  MEM/WB valid
- wb_data  out  16  regfile write data
- wb_drid  out  3  regfile destination
- wb_load_regfile  out  1  write regfile
- wb_load_cc  out  1  update CC
- wb_cc  out  3  new nzp

Behaviour:
- State machine states:
  - FIRST: default, and the state after reset.
  - SECOND: second access of LDI/STI.
  - Register ind_addr (16) holds the pointer read by the first LDI/STI access.
- Memory op classes:
  - LDR, LDB, STR, STB, TRAP: one access.
  - LDI, STI: two accesses.
  - All other opcodes: no access.
- Requests are combinational. In FIRST with ex_valid and a memory op, assert dmem_read or dmem_write. They are forced low while reset is high.
- First-access address:
  - ex_alu_out; bit 0 forced to 0 for word ops.
  - TRAP: zext(trapvect8) << 1.
- LDI/STI first access is always a word read.
  - On dmem_resp: ind_addr <= dmem_rdata, state -> SECOND.
- SECOND: access at {ind_addr[15:1], 0}.
  - LDI: word read. STI: word write.
  - On dmem_resp: complete, state -> FIRST.
- Word ops: byte_enable = 11; wdata = ex_sr_data.
- STB:
  - wdata = {sr[7:0], sr[7:0]}.
  - byte_enable = 10 if address[0] = 1, else 01.
- LDB: select byte by address[0] (1 = high), then sign-extend to 16 bits.
- Read/write not mid-access: byte_enable = 00, wdata = 0.
- mem_stall = ex_valid & memop & ~(final access & dmem_resp).
  - A zero-wait response (resp in the request cycle) is legal and completes in that cycle.
- Completion cycle:
  - Non-memory op: the cycle ex_valid is high.
  - Memory op: the final dmem_resp cycle.
  - At the rising edge ending it, the MEM/WB register loads and wb_valid <= 1.
  - In any other cycle wb_valid <= 0.
- wb_data:
  - ADD/AND/NOT/SHF/LEA: ex_alu_out.
  - Loads: aligned read data.
  - JSR/TRAP: ex_pc.
- wb_load_regfile is high for: ADD, AND, NOT, SHF, LEA, LDR, LDB, LDI, JSR, TRAP.
- wb_load_cc is high for: ADD, AND, NOT, SHF, LDR, LDB, LDI.
- wb_cc is computed from wb_data: n = bit15; z = (data == 0); otherwise p.
- Control flow, driven only in the completion cycle, otherwise pcmux_sel = 0 and pc_target = 0:
  - BR taken iff |(ex_ir[11:9] & ex_cc): pcmux_sel = 1, pc_target = ex_alu_out.
  - JMP/JSR: pcmux_sel = 1, pc_target = ex_alu_out.
  - TRAP: pcmux_sel = 2, pc_target = dmem_rdata.
- ex_valid low: no requests, no stall, wb_valid <= 0; state holds.
- Reset, including mid-access: state = FIRST, ind_addr = 0, wb_* all = 0. A pending access is abandoned; late responses are ignored while state is FIRST and no request is asserted.
- Inputs must be stable while mem_stall is high (upstream guarantees it).

Decomposition:
- Package lc3b_types: lc3b_word, lc3b_reg, lc3b_nzp, lc3b_opcode enum, mem_state enum {FIRST, SECOND}.
- Sub-module mem_align (combinational): byte-lane enable, store replication, load byte select and sign-extension.

Test Plan:
- ADD, ex_alu_out = 0x8000, drid = 3 -> no dmem request, mem_stall 0; next cycle wb_data = 0x8000, wb_drid = 3, wb_load_cc = 1, wb_cc = 100.
- LDB at 0x1235, memory word 0x80FF, resp after 3 cycles -> byte_enable 10; mem_stall high for 3 cycles; wb_data = 0xFF80, wb_cc = 100.
- STB at 0x2000, sr = 0x12AB, zero-wait resp -> dmem_write = 1, wdata = 0xABAB, byte_enable 01, mem_stall 0, wb_load_regfile = 0.
- LDI: ex_alu_out = 0x0100, mem[0x0100] = 0x0300, mem[0x0300] = 0x0000 -> two reads (addresses 0x0100 then 0x0300); wb_data = 0, wb_cc = 010.
- TRAP x25, mem[0x004A] = 0x3000, ex_pc = 0x0A02 -> read at 0x004A; completion: pcmux_sel = 2, pc_target = 0x3000, wb_data = 0x0A02, wb_drid = 7.
- BRz with ex_cc = 010, target 0x0040 -> pcmux_sel = 1, pc_target = 0x0040. With ex_cc = 001 -> pcmux_sel = 0. Reset asserted during the SECOND state of an LDI -> state FIRST, no request, wb_valid 0.

Source files
------------

// File: rtl/lc3b_types.sv
// LC-3b shared types for the pipeline stages.
// Word, register id, condition code, opcode and memory-stage state.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_nzp;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } mem_state;

  function automatic lc3b_nzp gen_cc(input lc3b_word d);
    return {d[15], d == 16'h0, ~d[15] & (d != 16'h0)};
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane handling for data memory accesses.
// Lane enables, store byte replication, load byte select with sign-extend.
module mem_stage_align
  import lc3b_types::*;
(
  input  logic       active,
  input  logic       byte_op,
  input  logic       addr_lsb,
  input  lc3b_word   sr_data,
  input  lc3b_word   rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   load_data
);

  logic [7:0] sel_byte;

  always_comb begin
    byte_enable = 2'b00;
    wdata       = 16'h0;
    if (active) begin
      if (byte_op) begin
        byte_enable = addr_lsb ? 2'b10 : 2'b01;
        wdata       = {sr_data[7:0], sr_data[7:0]};
      end else begin
        byte_enable = 2'b11;
        wdata       = sr_data;
      end
    end
  end

  always_comb begin
    sel_byte  = addr_lsb ? rdata[15:8] : rdata[7:0];
    load_data = byte_op ? {{8{sel_byte[7]}}, sel_byte} : rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b memory stage: data access, indirect/trap reads,
// control-flow resolution and the MEM/WB pipe register.
module mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_ir,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_sr_data,
  input  logic [15:0] ex_pc,
  input  logic [2:0]  ex_drid,
  input  logic [2:0]  ex_cc,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic [1:0]  pcmux_sel,
  output logic [15:0] pc_target,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_drid,
  output logic        wb_load_regfile,
  output logic        wb_load_cc,
  output logic [2:0]  wb_cc
);

  lc3b_opcode op;
  mem_state   state_q, state_d;
  lc3b_word   ind_addr_q, ind_addr_d;

  logic     wb_valid_q, wb_valid_d;
  lc3b_word wb_data_q, wb_data_d;
  lc3b_reg  wb_drid_q, wb_drid_d;
  logic     wb_ld_rf_q, wb_ld_rf_d;
  logic     wb_ld_cc_q, wb_ld_cc_d;
  lc3b_nzp  wb_cc_q, wb_cc_d;

  logic     one_acc, two_acc, memop, in_second;
  logic     final_acc, access, is_wr, byte_op;
  logic     is_load, alu_wb, link_wb, done;
  lc3b_word load_data;
  logic     unused_ok;

  assign op        = lc3b_opcode'(ex_opcode);
  assign unused_ok = ^{ex_ir[15:12], ex_ir[8], ind_addr_q[0]};

  always_comb begin
    one_acc   = op inside {OP_LDR, OP_LDB, OP_STR, OP_STB, OP_TRAP};
    two_acc   = op inside {OP_LDI, OP_STI};
    memop     = one_acc | two_acc;
    is_load   = op inside {OP_LDR, OP_LDB, OP_LDI};
    alu_wb    = op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA};
    link_wb   = op inside {OP_JSR, OP_TRAP};
    in_second = (state_q == SECOND);
    final_acc = ~two_acc | in_second;
    access    = ex_valid & memop & ~reset;
    byte_op   = op inside {OP_LDB, OP_STB};
    is_wr     = (op inside {OP_STR, OP_STB})
              | ((op == OP_STI) & in_second);
  end

  always_comb begin
    dmem_address = {ex_alu_out[15:1], 1'b0};
    if (two_acc && in_second)
      dmem_address = {ind_addr_q[15:1], 1'b0};
    else if (op == OP_TRAP)
      dmem_address = {7'b0, ex_ir[7:0], 1'b0};
    else if (byte_op)
      dmem_address = ex_alu_out;
  end

  assign dmem_read  = access & ~is_wr;
  assign dmem_write = access & is_wr;

  mem_stage_align u_align (
    .active      (access),
    .byte_op     (byte_op),
    .addr_lsb    (dmem_address[0]),
    .sr_data     (ex_sr_data),
    .rdata       (dmem_rdata),
    .byte_enable (dmem_byte_enable),
    .wdata       (dmem_wdata),
    .load_data   (load_data)
  );

  assign mem_stall = ex_valid & memop & ~(final_acc & dmem_resp);
  assign done      = ex_valid & (~memop | (final_acc & dmem_resp));

  always_comb begin
    state_d    = state_q;
    ind_addr_d = ind_addr_q;
    if (access && dmem_resp) begin
      if (two_acc && !in_second) begin
        state_d    = SECOND;
        ind_addr_d = dmem_rdata;
      end else if (in_second) begin
        state_d = FIRST;
      end
    end
  end

  always_comb begin
    pcmux_sel = 2'd0;
    pc_target = 16'h0;
    if (done) begin
      unique case (1'b1)
        op == OP_BR: begin
          if (|(ex_ir[11:9] & ex_cc)) begin
            pcmux_sel = 2'd1;
            pc_target = ex_alu_out;
          end
        end
        op inside {OP_JMP, OP_JSR}: begin
          pcmux_sel = 2'd1;
          pc_target = ex_alu_out;
        end
        op == OP_TRAP: begin
          pcmux_sel = 2'd2;
          pc_target = dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wb_valid_d = done;
    wb_data_d  = wb_data_q;
    wb_drid_d  = wb_drid_q;
    wb_ld_rf_d = wb_ld_rf_q;
    wb_ld_cc_d = wb_ld_cc_q;
    wb_cc_d    = wb_cc_q;
    if (done) begin
      wb_data_d  = is_load ? load_data
                 : link_wb ? ex_pc : ex_alu_out;
      wb_drid_d  = ex_drid;
      wb_ld_rf_d = alu_wb | is_load | link_wb;
      wb_ld_cc_d = is_load | (alu_wb & (op != OP_LEA));
      wb_cc_d    = gen_cc(wb_data_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FIRST;
      ind_addr_q <= 16'h0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 16'h0;
      wb_drid_q  <= 3'h0;
      wb_ld_rf_q <= 1'b0;
      wb_ld_cc_q <= 1'b0;
      wb_cc_q    <= 3'h0;
    end else begin
      state_q    <= state_d;
      ind_addr_q <= ind_addr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_drid_q  <= wb_drid_d;
      wb_ld_rf_q <= wb_ld_rf_d;
      wb_ld_cc_q <= wb_ld_cc_d;
      wb_cc_q    <= wb_cc_d;
    end
  end

  assign wb_valid        = wb_valid_q;
  assign wb_data         = wb_data_q;
  assign wb_drid         = wb_drid_q;
  assign wb_load_regfile = wb_ld_rf_q;
  assign wb_load_cc      = wb_ld_cc_q;
  assign wb_cc           = wb_cc_q;

endmodule
